// File: rtl/varredura_servo_pkg.sv
// Shared constants for the servo sweep sequencer:
// state codes, board timing defaults and position limits.
package varredura_servo_pkg;

    localparam logic [2:0] INICIAL   = 3'd0;
    localparam logic [2:0] PARADO    = 3'd1;
    localparam logic [2:0] POSICIONA = 3'd2;
    localparam logic [2:0] PEDE      = 3'd3;
    localparam logic [2:0] AGUARDA   = 3'd4;
    localparam logic [2:0] AVANCA    = 3'd5;

    // 50 MHz board: 1 s settling, 0.5 s measurement timeout
    localparam int TEMPO_POSICAO_PADRAO = 50_000_000;
    localparam int TEMPO_TIMEOUT_PADRAO = 25_000_000;

    localparam logic [2:0] POS_MIN = 3'd0;
    localparam logic [2:0] POS_MAX = 3'd7;

endpackage

// File: rtl/varredura_servo_contador_m.sv
// Generic modulo-M counter with clear, enable and terminal-count flag.
// Width is $clog2(M), never less than one bit.
module contador_m #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] q;

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            q <= '0;
        end else if (conta) begin
            if (q == ULTIMO) q <= '0;
            else             q <= q + 1'b1;
        end
    end

    assign fim = (q == ULTIMO);

endmodule

// File: rtl/varredura_servo.sv
// Sweep sequencer: walks posicao 0..7..0, settles, requests a
// measurement and steps on completion or timeout.
module varredura_servo
    import varredura_servo_pkg::*;
#(
    parameter int TEMPO_POSICAO = TEMPO_POSICAO_PADRAO,
    parameter int TEMPO_TIMEOUT = TEMPO_TIMEOUT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       medida_pronta,
    output logic [2:0] posicao,
    output logic       sentido,
    output logic       pede_medida,
    output logic       fim_posicao,
    output logic       erro_medida,
    output logic [2:0] db_estado
);

    logic [2:0] estado;
    logic       fim_pos;
    logic       fim_to;

    contador_m #(.M(TEMPO_POSICAO)) u_conta_pos (
        .clock (clock),
        .reset (reset),
        .zera  (estado != POSICIONA),
        .conta (estado == POSICIONA && ligar),
        .fim   (fim_pos)
    );

    contador_m #(.M(TEMPO_TIMEOUT)) u_conta_to (
        .clock (clock),
        .reset (reset),
        .zera  (estado != AGUARDA),
        .conta (estado == AGUARDA && ligar),
        .fim   (fim_to)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= INICIAL;
            posicao     <= POS_MIN;
            sentido     <= 1'b1;
            pede_medida <= 1'b0;
            fim_posicao <= 1'b0;
            erro_medida <= 1'b0;
        end else begin
            pede_medida <= 1'b0;
            fim_posicao <= 1'b0;
            erro_medida <= 1'b0;
            case (estado)
                INICIAL: estado <= PARADO;
                PARADO: begin
                    if (ligar) estado <= POSICIONA;
                end
                POSICIONA: begin
                    if (!ligar) begin
                        estado <= PARADO;
                    end else if (fim_pos) begin
                        estado      <= PEDE;
                        pede_medida <= 1'b1;
                    end
                end
                PEDE: begin
                    if (!ligar) estado <= PARADO;
                    else        estado <= AGUARDA;
                end
                AGUARDA: begin
                    if (!ligar) begin
                        estado <= PARADO;
                    end else if (medida_pronta) begin
                        estado      <= AVANCA;
                        fim_posicao <= 1'b1;
                    end else if (fim_to) begin
                        estado      <= AVANCA;
                        fim_posicao <= 1'b1;
                        erro_medida <= 1'b1;
                    end
                end
                AVANCA: begin
                    estado <= POSICIONA;
                    // endpoints reverse direction without a second dwell
                    if (sentido) begin
                        if (posicao == POS_MAX) begin
                            posicao <= POS_MAX - 3'd1;
                            sentido <= 1'b0;
                        end else begin
                            posicao <= posicao + 3'd1;
                        end
                    end else begin
                        if (posicao == POS_MIN) begin
                            posicao <= POS_MIN + 3'd1;
                            sentido <= 1'b1;
                        end else begin
                            posicao <= posicao - 3'd1;
                        end
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_varredura_servo.sv
// Randomized bench for varredura_servo against an elapsed-time
// reference model of the sweep, checked every cycle.
module tb_varredura_servo;

    localparam int TP = 4;
    localparam int TO = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ligar = 1'b0;
    logic       medida_pronta = 1'b0;
    logic [2:0] posicao;
    logic       sentido;
    logic       pede_medida;
    logic       fim_posicao;
    logic       erro_medida;
    logic [2:0] db_estado;

    int total = 0;
    int bad = 0;

    varredura_servo #(
        .TEMPO_POSICAO(TP),
        .TEMPO_TIMEOUT(TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .medida_pronta (medida_pronta),
        .posicao       (posicao),
        .sentido       (sentido),
        .pede_medida   (pede_medida),
        .fim_posicao   (fim_posicao),
        .erro_medida   (erro_medida),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // model: m_t = cycles since entering the settling phase
    bit m_init, m_run, m_adv, m_err;
    int m_t, m_pos;
    bit m_dir;
    bit armed = 0;

    function automatic int m_estado();
        if (m_init)   return 0;
        if (!m_run)   return 1;
        if (m_adv)    return 5;
        if (m_t < TP) return 2;
        if (m_t == TP) return 3;
        return 4;
    endfunction

    task automatic model_step(input bit r, input bit l, input bit mp);
        if (r) begin
            m_init = 1; m_run = 0; m_adv = 0; m_err = 0;
            m_t = 0; m_pos = 0; m_dir = 1;
        end else if (m_init) begin
            m_init = 0;
        end else if (m_adv) begin
            if (m_dir && m_pos == 7) begin m_pos = 6; m_dir = 0; end
            else if (!m_dir && m_pos == 0) begin m_pos = 1; m_dir = 1; end
            else m_pos = m_dir ? m_pos + 1 : m_pos - 1;
            m_adv = 0; m_err = 0; m_t = 0;
        end else if (!m_run) begin
            if (l) begin m_run = 1; m_t = 0; end
        end else if (!l) begin
            m_run = 0;
        end else if (m_t <= TP) begin
            m_t++;
        end else if (mp) begin
            m_adv = 1; m_err = 0;
        end else if (m_t - TP - 1 == TO - 1) begin
            m_adv = 1; m_err = 1;
        end else begin
            m_t++;
        end
    endtask

    task automatic ciclo(input bit r, input bit l, input bit mp);
        @(negedge clock);
        if (armed) begin
            check("posicao", int'(posicao), m_pos);
            check("sentido", int'(sentido), int'(m_dir));
            check("estado", int'(db_estado), m_estado());
            check("pede", int'(pede_medida), int'(m_estado() == 3));
            check("fim", int'(fim_posicao), int'(m_adv));
            check("erro", int'(erro_medida), int'(m_adv && m_err));
        end
        reset = r;
        ligar = l;
        medida_pronta = mp;
        model_step(r, l, mp);
        armed = 1;
    endtask

    initial begin
        bit hit;
        ciclo(1, 0, 0);
        ciclo(1, 0, 0);
        ciclo(0, 0, 0);
        ciclo(0, 0, 0);
        // full sweep answered on the first AGUARDA cycle
        for (int i = 0; i < 220; i++) ciclo(0, 1, 1);
        // no answers: timeouts
        for (int i = 0; i < 60; i++) ciclo(0, 1, 0);
        // answer lands on the last timeout cycle
        for (int i = 0; i < 80; i++)
            ciclo(0, 1, m_run && !m_adv && m_t == TP + TO);
        // stray answers during settling, occasional drops of ligar
        for (int i = 0; i < 200; i++)
            ciclo(0, $urandom_range(0, 15) != 0,
                  m_estado() == 2 || $urandom_range(0, 7) == 0);
        // reset while waiting at posicao 5 going down
        hit = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (m_estado() == 4 && m_pos == 5 && !m_dir) begin
                ciclo(1, 1, 0);
                hit = 1;
            end else begin
                ciclo(0, 1, !(m_pos == 5 && !m_dir));
            end
        end
        check("reset_hit", int'(hit), 1);
        ciclo(0, 1, 0);
        for (int i = 0; i < 2500; i++)
            ciclo($urandom_range(0, 299) == 0,
                  $urandom_range(0, 19) != 0,
                  $urandom_range(0, 3) == 0);
        ciclo(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/varredura_servo.md
# varredura_servo

Sweep sequencer that generates the 3-bit `posicao` command for the servo PWM stage, stepping 0→7→0 back and forth. At each position it waits a settling time, requests one measurement from the downstream sensor logic, and advances on completion or timeout. It sits directly upstream of the servo controller; its `posicao` output connects straight to that block's `posicao` input.

## Interface
- `TEMPO_POSICAO`, 50_000_000: settling cycles per position (1 s at 50 MHz); ≥1.
- `TEMPO_TIMEOUT`, 25_000_000: maximum cycles to wait for `medida_pronta`; ≥1.
- `clock` in 1: single system clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `ligar` in 1: sweep enable (level).
- `medida_pronta` in 1: one-cycle completion pulse from the measurement logic.
- `posicao` out 3: registered servo position command.
- `sentido` out 1: 1 = increasing, 0 = decreasing.
- `pede_medida` out 1: one-cycle measurement request.
- `fim_posicao` out 1: one-cycle pulse on every step.
- `erro_medida` out 1: one-cycle pulse when a step was forced by timeout.
- `db_estado` out 3: current FSM state code.

## Operation
- States/codes: INICIAL=0, PARADO=1, POSICIONA=2, PEDE=3, AGUARDA=4, AVANCA=5; codes 6–7 unreachable and recover to INICIAL.
- Reset (any state, any cycle): state INICIAL, `posicao`=0, `sentido`=1, both counters 0, all pulse outputs 0.
- INICIAL → PARADO unconditionally.
- PARADO: `posicao` and `sentido` held; `ligar`=1 → POSICIONA with settling counter 0.
- POSICIONA: `ligar`=0 → PARADO, counter cleared. Counter == `TEMPO_POSICAO`-1 → PEDE. Otherwise counter +1.
- PEDE: `pede_medida`=1 for this cycle only. `ligar`=0 → PARADO; otherwise → AGUARDA, timeout counter 0.
- AGUARDA: `ligar`=0 → PARADO, no step. Else `medida_pronta`=1 → AVANCA, normal. Else timeout counter == `TEMPO_TIMEOUT`-1 → AVANCA, timeout. Otherwise counter +1. `medida_pronta` takes priority over timeout in the same cycle.
- `medida_pronta` is ignored in every state except AGUARDA.
- AVANCA: `fim_posicao`=1. `erro_medida`=1 only if entered by timeout. Then → POSICIONA, counter 0. `ligar` is not sampled, so the step always completes.
- Step rule, applied at the end of AVANCA:
  - `sentido`=1, `posicao`<7: `posicao`+1.
  - `sentido`=1, `posicao`=7: `posicao`=6, `sentido`=0.
  - `sentido`=0, `posicao`>0: `posicao`−1.
  - `sentido`=0, `posicao`=0: `posicao`=1, `sentido`=1.
- The endpoints 0 and 7 are held once per pass (no double dwell). `posicao` never wraps modulo 8.
- Re-enabling from PARADO restarts a full settling interval at the held position.

## Timing
- `posicao`/`sentido` change on the clock edge that leaves AVANCA; the new value is visible in the first POSICIONA cycle.
- Outputs are Moore-style:
  - `pede_medida` is a decode of PEDE.
  - `fim_posicao` is a decode of AVANCA.
  - `erro_medida` is registered alongside the transition into AVANCA.
  - All are glitch-free.
- Per-position period with `medida_pronta` in the first AGUARDA cycle: `TEMPO_POSICAO`+3 cycles.
- Per-position period with timeout: `TEMPO_POSICAO`+`TEMPO_TIMEOUT`+2 cycles.
- Counter widths: `$clog2` of the respective parameter, minimum 1 bit. Comparisons are equality against parameter−1; no overflow is possible.

## Structure
- Shared package holds:
  - state codes (3-bit localparams);
  - default `TEMPO_POSICAO`/`TEMPO_TIMEOUT` for the 50 MHz board;
  - `POS_MIN`=0 and `POS_MAX`=7.
- One generic sub-module, `contador_m` (parameter M; ports `zera`, `conta`, `fim`), instantiated twice: settling and timeout.
- FSM next-state logic, output decode, and the position/direction register live in `varredura_servo`.

## Test plan
All scenarios use `TEMPO_POSICAO`=4 and `TEMPO_TIMEOUT`=6.
- Reset held 2 cycles → all pulses 0, `posicao`=0, `sentido`=1; after release `db_estado` shows 0, then 1.
- `ligar`=1, `medida_pronta` answered in the first AGUARDA cycle → `posicao` sequence 0,1,…,7,6,…,0,1, one step every 7 cycles. `sentido` goes to 0 in the step leaving 7 and to 1 in the step leaving 0.
- `medida_pronta` never asserted → after PEDE, exactly 6 AGUARDA cycles, then AVANCA with `erro_medida`=1 and `fim_posicao`=1; `posicao` advances.
- `ligar` dropped in POSICIONA at `posicao`=3 → PARADO next cycle, `posicao` stays 3. Re-assert `ligar` → PEDE after exactly 4 POSICIONA cycles.
- `medida_pronta` coincides with the last timeout cycle → AVANCA with `erro_medida`=0. A `medida_pronta` pulse during POSICIONA → no effect on state or timing.
- `reset` during AGUARDA at `posicao`=5, `sentido`=0 → next cycle `posicao`=0, `sentido`=1, state INICIAL, no `fim_posicao` pulse.
